// File: rtl/alu_pkg.sv
// Opcodes, command codes and step record shared by the skein ALU control path.
package alu_pkg;

  localparam logic [3:0] OP_WR_P       = 4'h1;
  localparam logic [3:0] OP_WR_P_LO    = 4'h2;
  localparam logic [3:0] OP_ROT_P1     = 4'h3;
  localparam logic [3:0] OP_ROT_P16    = 4'h4;
  localparam logic [3:0] OP_WR_S       = 4'h5;
  localparam logic [3:0] OP_WR_S_LO    = 4'h6;
  localparam logic [3:0] OP_XOR        = 4'h7;
  localparam logic [3:0] OP_ADD        = 4'h8;
  localparam logic [3:0] OP_WR_BC      = 4'h9;
  localparam logic [3:0] OP_CMP        = 4'hA;
  localparam logic [3:0] OP_NONCE_PASS = 4'hB;
  localparam logic [3:0] OP_P_PASS     = 4'hC;
  localparam logic [3:0] OP_ROT_S16    = 4'hD;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_LOAD_P  = 3'd0;
  localparam cmd_t CMD_LOAD_S  = 3'd1;
  localparam cmd_t CMD_ADD     = 3'd2;
  localparam cmd_t CMD_XOR     = 3'd3;
  localparam cmd_t CMD_CMP     = 3'd4;
  localparam cmd_t CMD_PASS    = 3'd5;
  localparam cmd_t CMD_ROTL    = 3'd6;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] operand;
  } step_t;

endpackage

// File: rtl/alu_sequencer.sv
// Expands one high-level ALU command into a registered stream of opcode/operand steps.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ROT_W       = 5,
  parameter logic [3:0]  IDLE_OPCODE = OP_NONCE_PASS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [31:0]      cmd_data_i,
  input  logic [ROT_W-1:0] cmd_rot_i,
  output logic [3:0]       opcode_o,
  output logic [15:0]      operand_o,
  output logic             step_valid_o,
  output logic             done_o,
  output logic             err_o
);

  // One extra bit so a full-length rotate (2^ROT_W steps incl. the clear) never wraps.
  localparam int unsigned CNT_W = ROT_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  function automatic cnt_t cmd_len(input cmd_t op, input logic [ROT_W-1:0] rot);
    cnt_t len;
    len = '0;
    case (op)
      CMD_LOAD_P, CMD_LOAD_S:                  len = cnt_t'(3);
      CMD_ADD, CMD_XOR, CMD_CMP, CMD_PASS:     len = cnt_t'(1);
      CMD_ROTL:                                len = cnt_t'(rot) + cnt_t'(1);
      default:                                 len = '0;
    endcase
    return len;
  endfunction

  function automatic step_t step_at(input cmd_t op, input cnt_t idx, input logic [31:0] data);
    step_t s;
    s.opcode  = IDLE_OPCODE;
    s.operand = '0;
    case (op)
      CMD_LOAD_P, CMD_LOAD_S: begin
        if (idx == cnt_t'(1)) begin
          s.opcode = (op == CMD_LOAD_P) ? OP_WR_P_LO : OP_WR_S_LO;
        end else begin
          s.opcode  = (op == CMD_LOAD_P) ? OP_WR_P : OP_WR_S;
          s.operand = (idx == '0) ? data[31:16] : data[15:0];
        end
      end
      CMD_ADD:  s.opcode = OP_ADD;
      CMD_XOR:  s.opcode = OP_XOR;
      CMD_CMP: begin
        s.opcode  = OP_CMP;
        s.operand = data[15:0];
      end
      CMD_PASS: s.opcode = OP_P_PASS;
      CMD_ROTL: s.opcode = (idx == '0) ? OP_WR_BC : OP_ROT_P1;
      default:  s.opcode = IDLE_OPCODE;
    endcase
    return s;
  endfunction

  state_t      state_reg, state_next;
  cnt_t        cnt_reg, cnt_next;
  cnt_t        len_reg, len_next;
  cmd_t        op_reg, op_next;
  logic [31:0] data_reg, data_next;
  step_t       step_reg, step_next;
  logic        step_valid_reg, step_valid_next;
  logic        ready_reg, ready_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  cnt_t        acc_len;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      len_reg          <= '0;
      op_reg           <= '0;
      data_reg         <= '0;
      step_reg.opcode  <= IDLE_OPCODE;
      step_reg.operand <= '0;
      step_valid_reg   <= 1'b0;
      ready_reg        <= 1'b1;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      len_reg        <= len_next;
      op_reg         <= op_next;
      data_reg       <= data_next;
      step_reg       <= step_next;
      step_valid_reg <= step_valid_next;
      ready_reg      <= ready_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    len_next          = len_reg;
    op_next           = op_reg;
    data_next         = data_reg;
    step_next.opcode  = IDLE_OPCODE;
    step_next.operand = '0;
    step_valid_next   = 1'b0;
    ready_next        = 1'b1;
    done_next         = 1'b0;
    err_next          = 1'b0;
    acc_len           = cmd_len(cmd_op_i, cmd_rot_i);

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid_i && ready_reg) begin
          op_next   = cmd_op_i;
          data_next = cmd_data_i;
          len_next  = acc_len;
          if (acc_len == '0) begin
            // Illegal command: nothing to issue, complete with error right away.
            done_next = 1'b1;
            err_next  = 1'b1;
          end else begin
            step_next       = step_at(cmd_op_i, '0, cmd_data_i);
            step_valid_next = 1'b1;
            ready_next      = 1'b0;
            cnt_next        = cnt_t'(1);
            state_next      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_reg == len_reg) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          step_next       = step_at(op_reg, cnt_reg, data_reg);
          step_valid_next = 1'b1;
          ready_next      = 1'b0;
          cnt_next        = cnt_reg + cnt_t'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign cmd_ready_o  = ready_reg;
  assign opcode_o     = step_reg.opcode;
  assign operand_o    = step_reg.operand;
  assign step_valid_o = step_valid_reg;
  assign done_o       = done_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, corner sequences, random vs. queue model.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [4:0]  cmd_rot;
  logic [3:0]  opcode;
  logic [15:0] operand;
  logic        step_valid;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.ROT_W(5), .IDLE_OPCODE(4'hB)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_data_i   (cmd_data),
    .cmd_rot_i    (cmd_rot),
    .opcode_o     (opcode),
    .operand_o    (operand),
    .step_valid_o (step_valid),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending step list plus completion flags for the current cycle.
  logic [19:0] exp_q[$];
  logic        done_m;
  logic        err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    done_m = 1'b0;
    err_m  = 1'b0;
  endtask

  task automatic model_build(input logic [2:0] op, input logic [31:0] d, input logic [4:0] r);
    case (op)
      3'd0: begin exp_q.push_back({4'h1, d[31:16]}); exp_q.push_back({4'h2, 16'h0}); exp_q.push_back({4'h1, d[15:0]}); end
      3'd1: begin exp_q.push_back({4'h5, d[31:16]}); exp_q.push_back({4'h6, 16'h0}); exp_q.push_back({4'h5, d[15:0]}); end
      3'd2: exp_q.push_back({4'h8, 16'h0});
      3'd3: exp_q.push_back({4'h7, 16'h0});
      3'd4: exp_q.push_back({4'hA, d[15:0]});
      3'd5: exp_q.push_back({4'hC, 16'h0});
      3'd6: begin
        exp_q.push_back({4'h9, 16'h0});
        for (int i = 0; i < int'(r); i++) exp_q.push_back({4'h3, 16'h0});
      end
      default: ;
    endcase
  endtask

  task automatic model_advance(input logic v, input logic [2:0] op, input logic [31:0] d, input logic [4:0] r);
    err_m = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      done_m = (exp_q.size() == 0);
    end else begin
      done_m = 1'b0;
      if (v) begin
        model_build(op, d, r);
        if (exp_q.size() == 0) begin
          done_m = 1'b1;
          err_m  = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [23:0] act, exp;
    act = {cmd_ready, step_valid, opcode, operand, done, err};
    if (exp_q.size() > 0) exp = {1'b0, 1'b1, exp_q[0], 1'b0, 1'b0};
    else                  exp = {1'b1, 1'b0, 4'hB, 16'h0, done_m, err_m};
    check("cycle_outputs", 32'(act), 32'(exp));
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic step_cycle(input logic v, input logic [2:0] op, input logic [31:0] d, input logic [4:0] r);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    cmd_rot   = r;
    check_outputs();
    model_advance(v, op, d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step_cycle(1'b0, 3'($urandom), $urandom, 5'($urandom));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  rot;
    int          n_steps;
    logic [19:0] first;
    logic [19:0] last;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n, done_cyc, k, dcount, scount;
    logic [19:0] first, last;
    logic got_done, err_seen;

    vecs[0] = '{3'd0, 32'hDEADBEEF, 5'd0,  3,  20'h1DEAD, 20'h1BEEF, 1'b0};
    vecs[1] = '{3'd1, 32'h12345678, 5'd0,  3,  20'h51234, 20'h55678, 1'b0};
    vecs[2] = '{3'd2, 32'hFFFFFFFF, 5'd0,  1,  20'h80000, 20'h80000, 1'b0};
    vecs[3] = '{3'd3, 32'hFFFFFFFF, 5'd0,  1,  20'h70000, 20'h70000, 1'b0};
    vecs[4] = '{3'd4, 32'h00011234, 5'd0,  1,  20'hA1234, 20'hA1234, 1'b0};
    vecs[5] = '{3'd5, 32'hCAFEF00D, 5'd9,  1,  20'hC0000, 20'hC0000, 1'b0};
    vecs[6] = '{3'd6, 32'hFFFFFFFF, 5'd5,  6,  20'h90000, 20'h30000, 1'b0};
    vecs[7] = '{3'd6, 32'h00000000, 5'd0,  1,  20'h90000, 20'h90000, 1'b0};
    vecs[8] = '{3'd6, 32'h00000000, 5'd31, 32, 20'h90000, 20'h30000, 1'b0};
    vecs[9] = '{3'd7, 32'h55AA55AA, 5'd3,  0,  20'h00000, 20'h00000, 1'b1};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_rot = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({cmd_ready, step_valid, opcode, operand, done, err}), 32'({1'b1, 1'b0, 4'hB, 16'h0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      step_cycle(1'b1, vecs[i].op, vecs[i].data, vecs[i].rot);
      n = 0; first = '0; last = '0; got_done = 1'b0; err_seen = 1'b0; done_cyc = -1; k = 1;
      while (!got_done && k < 40) begin
        if (step_valid) begin
          if (n == 0) first = {opcode, operand};
          last = {opcode, operand};
          n++;
        end
        if (done) begin
          got_done = 1'b1;
          done_cyc = k;
          err_seen = err;
        end
        idle_cycle();
        k++;
      end
      $display("cmd op=%0d data=%h rot=%0d steps=%0d done@%0d err=%0b", vecs[i].op, vecs[i].data, vecs[i].rot, n, done_cyc, err_seen);
      check("vec_steps", 32'(n), 32'(vecs[i].n_steps));
      check("vec_first", 32'(first), 32'(vecs[i].first));
      check("vec_last", 32'(last), 32'(vecs[i].last));
      check("vec_err", 32'(err_seen), 32'(vecs[i].err));
      check("vec_done_cycle", 32'(done_cyc), 32'(vecs[i].n_steps + 1));
    end

    // ADD then XOR with valid held high
    step_cycle(1'b1, 3'd2, 32'h0, 5'd0);
    check("b2b_add", 32'(opcode), 32'h8);
    step_cycle(1'b1, 3'd3, 32'h0, 5'd0);
    check("b2b_done_ready", 32'({done, cmd_ready}), 32'h3);
    step_cycle(1'b1, 3'd3, 32'h0, 5'd0);
    check("b2b_xor", 32'(opcode), 32'h7);
    idle_cycle();
    check("b2b_done2", 32'(done), 32'h1);
    idle_cycle();
    $display("cmd b2b add/xor complete");

    // Valid pulsed while LOAD_S is busy
    step_cycle(1'b1, 3'd1, 32'hA5A5C3C3, 5'd0);
    dcount = 0; scount = 0;
    for (int c = 1; c < 8; c++) begin
      if (done) dcount++;
      if (step_valid) scount++;
      step_cycle(c == 2, 3'd2, 32'h0, 5'd0);
    end
    $display("cmd load_s with busy pulse steps=%0d dones=%0d", scount, dcount);
    check("busy_done_count", 32'(dcount), 32'd1);
    check("busy_step_count", 32'(scount), 32'd3);

    // Reset in the middle of LOAD_P
    step_cycle(1'b1, 3'd0, 32'hDEADBEEF, 5'd0);
    idle_cycle();
    check("rst_mid_step2", 32'({opcode, operand}), 32'h20000);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 32'({cmd_ready, step_valid, opcode}), 32'({1'b1, 1'b0, 4'hB}));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) dcount++;
      idle_cycle();
    end
    check("rst_no_done", 32'(dcount), 32'd0);
    $display("cmd load_p aborted by reset");

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [4:0] r;
      r = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      if (cmd_ready && $urandom_range(0, 2) != 0)
        $display("cmd random op=%0d rot=%0d", cmd_op, r);
      step_cycle(1'($urandom_range(0, 2) != 0), 3'($urandom), $urandom, r);
    end
    for (int c = 0; c < 40; c++) idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
